// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART transmit buffer slice.
package uart_pkg;
  localparam int BYTE_W        = 8;
  localparam int DEFAULT_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte handshake between the transmit buffer (master) and uart_tx (slave).
interface uart_tx_fifo_if;
  import uart_pkg::*;

  logic              uart_tx_en;
  logic [BYTE_W-1:0] uart_tx_data;
  logic              uart_tx_busy;

  modport master (output uart_tx_en, output uart_tx_data, input uart_tx_busy);
  modport slave  (input uart_tx_en, input uart_tx_data, output uart_tx_busy);
endinterface

// File: rtl/uart_byte_fifo.sv
// Generic byte FIFO with registered fill level and sticky overflow; usable on TX or RX side.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [BYTE_W-1:0] rd_data,
  input  logic              flush,
  input  logic              clr_overflow,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic              overflow
);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  logic [BYTE_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  logic [AW:0]       count_nxt_s;
  logic              full_r;
  logic              empty_r;
  logic              overflow_r;
  logic              push_s;
  logic              pop_s;
  logic              ovf_set_s;

  // Qualify requests against registered full/empty; flush overrides any same-cycle push.
  always_comb begin
    push_s      = wr_en && !full_r && !flush;
    pop_s       = rd_en && !empty_r;
    ovf_set_s   = wr_en && full_r && !flush;
    count_nxt_s = count_r;
    if (flush) begin
      count_nxt_s = '0;
    end else if (push_s && !pop_s) begin
      count_nxt_s = count_r + ONE_CNT;
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - ONE_CNT;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Pointers, level, status flags; full/empty precomputed so outputs come straight from flops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == FULL_CNT);
      empty_r <= (count_nxt_s == '0);
      if (flush) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + ONE_PTR;
        if (pop_s)  rd_ptr_r <= rd_ptr_r + ONE_PTR;
      end
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (clr_overflow) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Storage has no reset; contents are only read behind a valid pointer.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= wr_data;
  end

  assign rd_data  = mem_r[rd_ptr_r];
  assign full     = full_r;
  assign empty    = empty_r;
  assign count    = count_r;
  assign overflow = overflow_r;
endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer feeding uart_tx one byte at a time, with a bounded wait for the busy acknowledge.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int AW          = $clog2(DEPTH),
  parameter int ACK_TIMEOUT = 7
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              flush,
  input  logic              clr_overflow,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              tx_idle,
  uart_tx_fifo_if.master    tx
);
  localparam int            TW      = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);

  tx_state_e         state_r;
  tx_state_e         state_nxt_s;
  logic [TW-1:0]     to_cnt_r;
  logic [TW-1:0]     to_cnt_nxt_s;
  logic              pop_s;
  logic              fifo_empty_s;
  logic [BYTE_W-1:0] fifo_rd_data_s;
  logic              tx_en_r;
  logic [BYTE_W-1:0] tx_data_r;

  uart_byte_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk          (clk),
    .resetn       (resetn),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (pop_s),
    .rd_data      (fifo_rd_data_s),
    .flush        (flush),
    .clr_overflow (clr_overflow),
    .full         (full),
    .empty        (fifo_empty_s),
    .count        (count),
    .overflow     (overflow)
  );

  // Handshake next-state; a pop happens only on the IDLE->LAUNCH step.
  always_comb begin
    state_nxt_s  = state_r;
    to_cnt_nxt_s = to_cnt_r;
    pop_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s && !tx.uart_tx_busy) begin
          pop_s       = 1'b1;
          state_nxt_s = LAUNCH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LAUNCH: begin
        to_cnt_nxt_s = '0;
        state_nxt_s  = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx.uart_tx_busy) begin
          state_nxt_s = WAIT_DONE;
        end else if (to_cnt_r == TO_LAST) begin
          // No acknowledge in time: the byte is abandoned silently.
          to_cnt_nxt_s = to_cnt_r + TO_ONE;
          state_nxt_s  = IDLE;
        end else begin
          to_cnt_nxt_s = to_cnt_r + TO_ONE;
          state_nxt_s  = WAIT_ACK;
        end
      end
      WAIT_DONE: begin
        if (tx.uart_tx_busy) begin
          state_nxt_s = WAIT_DONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, timeout counter and registered launch outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= IDLE;
      to_cnt_r  <= '0;
      tx_en_r   <= 1'b0;
      tx_data_r <= 8'h00;
    end else begin
      state_r  <= state_nxt_s;
      to_cnt_r <= to_cnt_nxt_s;
      tx_en_r  <= (state_nxt_s == LAUNCH);
      if (pop_s) tx_data_r <= fifo_rd_data_s;
    end
  end

  assign empty           = fifo_empty_s;
  assign tx_idle         = fifo_empty_s && (state_r == IDLE);
  assign tx.uart_tx_en   = tx_en_r;
  assign tx.uart_tx_data = tx_data_r;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo with a simple uart_tx busy model.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  logic       clk;
  logic       resetn;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       clr_overflow;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       tx_idle;

  logic       force_busy;
  logic       model_on;
  int         model_cnt = 0;
  int         cyc = 0;
  logic [7:0] launch_q[$];
  int         launch_cyc_q[$];
  int         n_checks = 0;
  int         n_fail = 0;

  uart_tx_fifo_if tx_if();

  uart_tx_fifo #(.DEPTH(16), .AW(4), .ACK_TIMEOUT(7)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .flush        (flush),
    .clr_overflow (clr_overflow),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .tx_idle      (tx_idle),
    .tx           (tx_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transmitter model: busy rises the edge after en is seen and stays up 10 cycles.
  assign tx_if.uart_tx_busy = force_busy || (model_on && (model_cnt != 0));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_if.uart_tx_en) begin
      launch_q.push_back(tx_if.uart_tx_data);
      launch_cyc_q.push_back(cyc);
    end
    if (model_on && tx_if.uart_tx_en) model_cnt <= 10;
    else if (model_cnt != 0)          model_cnt <= model_cnt - 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_done(input int n_exp, input int bound, input string tag);
    int n;
    n = 0;
    while (!((launch_q.size() >= n_exp) && tx_idle) && (n < bound)) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < bound), 32'd1);
  endtask

  initial begin
    int n;
    int maxc;
    resetn = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; clr_overflow = 1'b0;
    force_busy = 1'b0; model_on = 1'b0;

    // Reset values and quiet idle
    #2 resetn = 1'b0;
    #1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_tx_idle", 32'(tx_idle), 32'd1);
    check("rst_en", 32'(tx_if.uart_tx_en), 32'd0);
    tick(3);
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("idle_cycle", 32'({empty, count, tx_idle, tx_if.uart_tx_en}), 32'h82);
    end

    // Single byte through the transmitter model
    model_on = 1'b1;
    push(8'hA5);
    check("single_count_e0", 32'(count), 32'd1);
    check("single_no_bypass", 32'(tx_if.uart_tx_en), 32'd0);
    tick(1);
    check("single_en_e1", 32'(tx_if.uart_tx_en), 32'd1);
    check("single_data_e1", 32'(tx_if.uart_tx_data), 32'hA5);
    check("single_count_e1", 32'(count), 32'd0);
    tick(1);
    check("single_en_e2", 32'(tx_if.uart_tx_en), 32'd0);
    n = 0;
    while (!tx_idle && n < 40) begin
      check("single_hold", 32'({tx_if.uart_tx_en, tx_if.uart_tx_data}), 32'h0A5);
      tick(1);
      n++;
    end
    check("single_cycles_to_idle", 32'(n), 32'd11);
    check("single_launch_count", 32'(launch_q.size()), 32'd1);

    // Fill past capacity with the transmitter held busy
    launch_q.delete();
    model_on = 1'b0; force_busy = 1'b1;
    for (int i = 0; i < 17; i++) push(8'(i));
    check("fill_count", 32'(count), 32'd16);
    check("fill_full", 32'(full), 32'd1);
    check("fill_overflow", 32'(overflow), 32'd1);
    clr_overflow = 1'b1; tick(1); clr_overflow = 1'b0;
    check("fill_clr_overflow", 32'(overflow), 32'd0);
    force_busy = 1'b0; model_on = 1'b1;
    wait_done(16, 1000, "fill_drain_time");
    check("fill_drain_n", 32'(launch_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < launch_q.size(); i++)
      check("fill_order", 32'(launch_q[i]), 32'(i));

    // Wrap-around with irregular gaps
    launch_q.delete();
    maxc = 0;
    for (int i = 0; i < 40; i++) begin
      n = 0;
      while (full && n < 100) begin tick(1); n++; end
      if (n >= 100) check("wrap_full_stuck", 32'(full), 32'd0);
      push(8'h40 + 8'(i));
      if (int'(count) > maxc) maxc = int'(count);
      for (int g = 0; g < (i % 4); g++) begin
        tick(1);
        if (int'(count) > maxc) maxc = int'(count);
      end
    end
    wait_done(40, 3000, "wrap_drain_time");
    check("wrap_n", 32'(launch_q.size()), 32'd40);
    for (int i = 0; i < 40 && i < launch_q.size(); i++)
      check("wrap_order", 32'(launch_q[i]), 32'h40 + 32'(i));
    check("wrap_max_le_depth", 32'(maxc <= 16), 32'd1);
    check("wrap_no_overflow", 32'(overflow), 32'd0);

    // Push at full with a same-edge pop, then flush with a push
    launch_q.delete();
    model_on = 1'b0; force_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
    check("simul_pre_count", 32'(count), 32'd16);
    force_busy = 1'b0; model_on = 1'b1;
    push(8'hEE);
    check("simul_overflow", 32'(overflow), 32'd1);
    check("simul_count", 32'(count), 32'd15);
    check("simul_launch", 32'({tx_if.uart_tx_en, tx_if.uart_tx_data}), 32'h180);
    flush = 1'b1;
    push(8'hDD);
    flush = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    check("flush_overflow_kept", 32'(overflow), 32'd1);
    wait_done(1, 200, "flush_inflight_time");
    check("flush_inflight_n", 32'(launch_q.size()), 32'd1);
    if (launch_q.size() > 0) check("flush_inflight_data", 32'(launch_q[0]), 32'h80);

    // Overflow set wins over a same-edge clear
    clr_overflow = 1'b1; tick(1); clr_overflow = 1'b0;
    check("setclr_pre", 32'(overflow), 32'd0);
    launch_q.delete();
    model_on = 1'b0; force_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(8'hC0 + 8'(i));
    clr_overflow = 1'b1;
    push(8'hFF);
    clr_overflow = 1'b0;
    check("setclr_overflow", 32'(overflow), 32'd1);
    check("setclr_count", 32'(count), 32'd16);
    flush = 1'b1; clr_overflow = 1'b1; tick(1); flush = 1'b0; clr_overflow = 1'b0;
    force_busy = 1'b0;
    tick(1);
    check("setclr_flushed", 32'({count, overflow, tx_idle}), 32'h01);
    check("setclr_no_launch", 32'(launch_q.size()), 32'd0);

    // Acknowledge timeout: busy never rises
    launch_q.delete(); launch_cyc_q.delete();
    model_on = 1'b0;
    push(8'h31);
    push(8'h32);
    wait_done(2, 100, "timeout_time");
    check("timeout_n", 32'(launch_q.size()), 32'd2);
    if (launch_q.size() >= 2) begin
      check("timeout_byte0", 32'(launch_q[0]), 32'h31);
      check("timeout_byte1", 32'(launch_q[1]), 32'h32);
      check("timeout_gap", 32'(launch_cyc_q[1] - launch_cyc_q[0]), 32'd9);
    end

    // Asynchronous reset while in WAIT_DONE
    launch_q.delete();
    model_on = 1'b1;
    push(8'h55);
    push(8'h56);
    n = 0;
    while (launch_q.size() < 1 && n < 20) begin tick(1); n++; end
    check("rstwd_launch_seen", 32'(n < 20), 32'd1);
    tick(2);
    check("rstwd_pre", 32'({tx_idle, count, tx_if.uart_tx_data}), 32'h0155);
    #1 resetn = 1'b0;
    #1;
    check("rstwd_empty", 32'(empty), 32'd1);
    check("rstwd_full", 32'(full), 32'd0);
    check("rstwd_count", 32'(count), 32'd0);
    check("rstwd_overflow", 32'(overflow), 32'd0);
    check("rstwd_tx_idle", 32'(tx_idle), 32'd1);
    check("rstwd_en", 32'(tx_if.uart_tx_en), 32'd0);
    check("rstwd_data", 32'(tx_if.uart_tx_data), 32'h00);
    tick(2);
    resetn = 1'b1;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte-wide transmit buffer placed directly upstream of the uart_tx transmitter. System logic pushes bytes at clock rate. The block stores them in a circular FIFO and hands them to uart_tx one at a time through the uart_tx_en / uart_tx_data / uart_tx_busy handshake. This decouples bursty producers from the slow serial line and reports fill level and overflow.

Parameters:
DEPTH, 16, FIFO entries; must be a power of two, minimum 2.
AW, 4, pointer width; equals log2(DEPTH).
ACK_TIMEOUT, 7, maximum cycles to wait for uart_tx_busy to rise after a launch.

Ports:
clk  input  1  system clock.
resetn  input  1  asynchronous active-low reset.
wr_en  input  1  push request; wr_data is sampled on the same edge.
wr_data  input  8  byte to enqueue.
flush  input  1  discard all queued bytes (synchronous).
clr_overflow  input  1  clear the sticky overflow flag.
full  output  1  FIFO holds DEPTH entries.
empty  output  1  FIFO holds 0 entries.
count  output  AW+1  current number of entries, 0..DEPTH.
overflow  output  1  sticky flag; a push was dropped because the FIFO was full.
tx_idle  output  1  FIFO empty and FSM in IDLE; all bytes handed off.
uart_tx_en  output  1  launch request to uart_tx.
uart_tx_data  output  8  byte presented to uart_tx; held stable from launch until the return to IDLE.
uart_tx_busy  input  1  transmitter busy, from uart_tx.

Behaviour:
- Reset values: the following take effect immediately on resetn low.
  - wr_ptr, rd_ptr, count = 0.
  - empty = 1, full = 0, overflow = 0, tx_idle = 1.
  - uart_tx_en = 0, uart_tx_data = 8'h00.
  - FSM = IDLE, timeout counter = 0.
  - Reset mid-transmission abandons the byte; the data in the storage array is don't-care.
- full, empty and count are decoded from registered state only; there is no combinational path from wr_en.
- Push: when wr_en=1 and full=0, the byte is written at wr_ptr, wr_ptr increments with wrap at DEPTH, and count increments.
- Push while full: the byte is dropped and overflow is set. This applies even if a pop occurs on the same edge.
- Pop: occurs only on the IDLE->LAUNCH transition. rd_ptr[data] is loaded into uart_tx_data, rd_ptr increments with wrap, and count decrements.
- Simultaneous push and pop (FIFO not full): count is unchanged and both pointers advance.
- No bypass path: a byte written into an empty FIFO at edge E0 is popped at edge E1 at the earliest. uart_tx_en is high between E1 and E2.
- flush: count and both pointers return to 0 on the next edge. flush wins over a same-cycle wr_en; that write is dropped and overflow is not set. flush does not abort a byte already launched; the FSM continues normally.
- overflow: a set event and clr_overflow on the same edge leaves overflow = 1 (set wins).
- FSM states: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE.
  - IDLE: when empty=0 and uart_tx_busy=0, pop and go to LAUNCH. Otherwise stay in IDLE.
  - LAUNCH: uart_tx_en=1 for exactly this one cycle. Clear the timeout counter and go to WAIT_ACK.
  - WAIT_ACK: if uart_tx_busy=1, go to WAIT_DONE. Otherwise increment the counter. When the counter reaches ACK_TIMEOUT, go to IDLE; the byte is considered lost and no flag is raised.
  - WAIT_DONE: stay while uart_tx_busy=1. Go to IDLE on the first cycle busy=0.
- uart_tx_en is 0 in every state except LAUNCH. Its value is registered.
- Throughput: at least 3 idle cycles between consecutive byte launches, in addition to the transmitter's busy period.
- Counter and pointer arithmetic is unsigned with modulo-DEPTH wrap. count uses AW+1 bits so that both 0 and DEPTH are representable.

Decomposition:
- Package uart_pkg holds:
  - the FSM state encoding as a 2-bit enumeration: IDLE=0, LAUNCH=1, WAIT_ACK=2, WAIT_DONE=3;
  - the byte width constant (8);
  - the default DEPTH.
- Sub-module uart_byte_fifo: a generic synchronous FIFO with storage, pointers, count, full/empty and overflow. It is reusable later as an RX buffer behind uart_rx.
- uart_tx_fifo itself contains the handshake FSM and the timeout counter.

Test Plan:
- Reset then idle: after reset, with no writes for 20 cycles, require empty=1, count=0, tx_idle=1, uart_tx_en=0 on every cycle.
- Single byte: write 8'hA5 at E0 against a transmitter model (busy rises 1 cycle after en and stays high 10 cycles). Require uart_tx_en high only between E1 and E2, uart_tx_data=8'hA5 held until the return to IDLE, and tx_idle=1 after busy falls.
- Fill and overflow (DEPTH=16, busy held high):
  - Write 17 bytes 0x00..0x10: require count=16, full=1, overflow=1, and byte 0x10 dropped.
  - Pulse clr_overflow: require overflow=0.
  - Release busy: require bytes 0x00..0x0F launched in order.
- Wrap-around: push and pop 40 bytes with random gaps. Require in-order delivery across pointer wrap and count never exceeding 16.
- Simultaneous events:
  - At count=16, wr_en with a same-cycle pop: require the write dropped and overflow=1.
  - flush with wr_en: require count=0 and overflow unchanged.
  - Set with clr_overflow: require overflow=1.
- Ack timeout and reset: hold busy=0 after a launch. Require return to IDLE after 7 WAIT_ACK cycles and the next byte then launches. Assert resetn low while in WAIT_DONE: require all outputs at reset values immediately.
